// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO regs.    |
// | Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
  localparam logic [2:0] c_OP_MULT  = 3'b001;
  localparam logic [2:0] c_OP_MULTU = 3'b010;
  localparam logic [2:0] c_OP_DIV   = 3'b011;
  localparam logic [2:0] c_OP_DIVU  = 3'b100;
  localparam logic [2:0] c_OP_MTHI  = 3'b101;
  localparam logic [2:0] c_OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;
  logic               r_done;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_abs;
  logic [WIDTH-1:0] w_rt_abs;
  logic             w_div_zero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;

  assign w_is_mul   = (mdop == c_OP_MULT) || (mdop == c_OP_MULTU);
  assign w_is_div   = (mdop == c_OP_DIV)  || (mdop == c_OP_DIVU);
  assign w_signed   = (mdop == c_OP_MULT) || (mdop == c_OP_DIV);
  assign w_rs_neg   = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg   = w_signed & rt_val[WIDTH-1];
  assign w_rs_abs   = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_abs   = w_rt_neg ? -rt_val : rt_val;
  assign w_div_zero = (rt_val == '0);

  // Shift-add step: upper half accumulates the multiplicand, multiplier shifts out the bottom.
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_b : {WIDTH{1'b0}})};

  // Restoring step: upper half is the partial remainder, lower half the dividend/quotient.
  assign w_shift    = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = S_FIX;
`else
          w_next = S_MUL;
`endif
        end else if (start && w_is_div) begin
          w_next = S_DIV;
        end
      end
      S_MUL:   if (r_cnt == c_LAST) w_next = S_FIX;
      S_DIV:   if (r_cnt == c_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_prod   <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (mdop == c_OP_MTHI) r_hi <= rs_val;
            if (mdop == c_OP_MTLO) r_lo <= rs_val;
            if (w_is_mul) begin
              r_is_div <= 1'b0;
              r_neg_q  <= w_rs_neg ^ w_rt_neg;
              r_b      <= w_rs_abs;
`ifdef MULDIV_FAST_MUL_EN
              r_prod   <= {{WIDTH{1'b0}}, w_rs_abs} * {{WIDTH{1'b0}}, w_rt_abs};
`else
              r_prod   <= {{WIDTH{1'b0}}, w_rt_abs};
`endif
            end
            if (w_is_div) begin
              r_is_div <= 1'b1;
              // Dividing the raw dividend by zero yields all-ones quotient and the dividend as remainder.
              if (w_div_zero) begin
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_b     <= '0;
                r_prod  <= {{WIDTH{1'b0}}, rs_val};
              end else begin
                r_neg_q <= w_rs_neg ^ w_rt_neg;
                r_neg_r <= w_rs_neg;
                r_b     <= w_rt_abs;
                r_prod  <= {{WIDTH{1'b0}}, w_rs_abs};
              end
            end
          end
        end
        S_MUL: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_prod <= {w_rem_next, r_prod[WIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
            r_hi <= r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
          end else begin
            {r_hi, r_lo} <= r_neg_q ? -r_prod : r_prod;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit: scoreboard bench for muldiv_unit with an arithmetic model.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  localparam logic [2:0] c_NONE  = 3'b000;
  localparam logic [2:0] c_MULT  = 3'b001;
  localparam logic [2:0] c_MULTU = 3'b010;
  localparam logic [2:0] c_DIV   = 3'b011;
  localparam logic [2:0] c_DIVU  = 3'b100;
  localparam logic [2:0] c_MTHI  = 3'b101;
  localparam logic [2:0] c_MTLO  = 3'b110;
  localparam int c_DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int c_MUL_LAT = 1;
`else
  localparam int c_MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mdop(mdop),
    .rs_val(rs_val), .rt_val(rt_val),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from plain arithmetic; called at the accepting edge.
  task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    exp_t            e;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      c_MULT: begin
        sp = sa * sb;
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.cyc = cyc + 1 + c_MUL_LAT;
        q.push_back(e);
      end
      c_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        e.hi = up[63:32]; e.lo = up[31:0]; e.cyc = cyc + 1 + c_MUL_LAT;
        q.push_back(e);
      end
      c_DIV, c_DIVU: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (op == c_DIV) begin
          sq = sa / sb; sr = sa % sb;
          e.hi = sr[31:0]; e.lo = sq[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
        e.cyc = cyc + 1 + c_DIV_LAT;
        q.push_back(e);
      end
      c_MTHI: m_hi = a;
      c_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    start = 1'b1; mdop = op; rs_val = a; rt_val = b;
    @(posedge clk);
    model_accept(op, a, b);
    @(negedge clk);
    start = 1'b0; mdop = c_NONE;
  endtask

  // Strobe a request without updating the model: the DUT is expected to ignore it.
  task automatic poke(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdop = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; mdop = c_NONE;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      q.delete();
      m_hi = '0;
      m_lo = '0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] eh, input logic [31:0] el);
    wait_idle();
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  // Monitor: pops the scoreboard on done, otherwise checks hi/lo hold and busy.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done=%b with no outstanding op", done);
        end else begin
          e = q.pop_front();
          chk("sb_hi", hi, e.hi);
          chk("sb_lo", lo, e.lo);
          chk("sb_latency", cyc, e.cyc);
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end else begin
        chk("hold_hi", hi, m_hi);
        chk("hold_lo", lo, m_lo);
        if (q.size() != 0 && cyc > q[0].cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_timeout: no done by cycle %0d, expected at %0d", cyc, q[0].cyc);
          e = q.pop_front();
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end
      chk("busy", busy, (q.size() != 0));
    end
  end

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    do_reset(2);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    issue(c_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    expect_result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(c_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    expect_result("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    issue(c_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    expect_result("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(c_DIVU, 32'd7, 32'd2);
    expect_result("divu", 32'd1, 32'd3);
    issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_result("div_ovf", 32'h0, 32'h8000_0000);
    issue(c_DIVU, 32'h1234_5678, 32'h0);
    expect_result("div_zero", 32'h1234_5678, 32'hFFFF_FFFF);

    issue(c_MULTU, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    poke(c_MTLO, 32'hDEAD_BEEF, 32'h0);
    poke(c_MULTU, 32'd7, 32'd7);
    expect_result("ignore_busy", 32'h0, 32'd15);

    issue(c_MTHI, 32'hCAFE_F00D, 32'h0);
    chk("mthi_hi", hi, 32'hCAFE_F00D);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);

    issue(c_DIV, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    do_reset(1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    issue(c_MULTU, 32'd2, 32'd3);
    expect_result("after_abort", 32'h0, 32'd6);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_val();
      b  = rnd_val();
      issue(op, a, b);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
